// File: rtl/stopwatch_bcd_counter_if.sv
// rtl/stopwatch_bcd_counter_if.sv - control, status and BCD digit bundle for the stopwatch counter
interface stopwatch_bcd_counter_if;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic       running;
  logic       lap_active;
  logic       overflow;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] cs_tens;
  logic [3:0] cs_ones;

  modport master (
    output tick_in, start_stop, clear, lap,
    input  running, lap_active, overflow,
    input  min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones
  );

  modport slave (
    input  tick_in, start_stop, clear, lap,
    output running, lap_active, overflow,
    output min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones
  );
endinterface

// File: rtl/stopwatch_bcd_counter.sv
// rtl/stopwatch_bcd_counter.sv - MM:SS.CC BCD stopwatch driven by rising edges of the 10 ms divider output
module stopwatch_bcd_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MINUTES = 59
) (
  input  logic                   clkin,
  input  logic                   rst,
  stopwatch_bcd_counter_if.slave sw
);

  localparam logic [3:0] MAX_MIN_T = 4'(MAX_MINUTES / 10);
  localparam logic [3:0] MAX_MIN_O = 4'(MAX_MINUTES % 10);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_LAP,
    ST_PAUSED
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     r_hist;
  logic                     r_overflow;
  // digit index: 0 cs_ones, 1 cs_tens, 2 sec_ones, 3 sec_tens, 4 min_ones, 5 min_tens
  logic [5:0][3:0]          r_cnt;
  logic [5:0][3:0]          r_snap;
  logic [5:0][3:0]          w_cnt_inc;
  logic [5:0][3:0]          w_disp;
  logic                     w_wrap;
  logic                     w_tick_pulse;
  logic                     w_cnt_en;
  logic                     w_load_snap;
  logic                     w_clear_cnt;

  assign w_tick_pulse = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_cnt_en     = w_tick_pulse & ((r_state == ST_RUN) | (r_state == ST_LAP));

  always_comb begin
    w_cnt_inc = r_cnt;
    w_wrap    = 1'b0;
    if (r_cnt[0] != 4'd9) begin
      w_cnt_inc[0] = r_cnt[0] + 4'd1;
    end else begin
      w_cnt_inc[0] = 4'd0;
      if (r_cnt[1] != 4'd9) begin
        w_cnt_inc[1] = r_cnt[1] + 4'd1;
      end else begin
        w_cnt_inc[1] = 4'd0;
        if (r_cnt[2] != 4'd9) begin
          w_cnt_inc[2] = r_cnt[2] + 4'd1;
        end else begin
          w_cnt_inc[2] = 4'd0;
          if (r_cnt[3] != 4'd5) begin
            w_cnt_inc[3] = r_cnt[3] + 4'd1;
          end else begin
            w_cnt_inc[3] = 4'd0;
            if ((r_cnt[5] == MAX_MIN_T) && (r_cnt[4] == MAX_MIN_O)) begin
              w_cnt_inc[4] = 4'd0;
              w_cnt_inc[5] = 4'd0;
              w_wrap       = 1'b1;
            end else if (r_cnt[4] != 4'd9) begin
              w_cnt_inc[4] = r_cnt[4] + 4'd1;
            end else begin
              w_cnt_inc[4] = 4'd0;
              w_cnt_inc[5] = r_cnt[5] + 4'd1;
            end
          end
        end
      end
    end
  end

  // clear outranks start_stop, which outranks lap; clear only acts from PAUSED
  always_comb begin
    w_state_nxt = r_state;
    w_load_snap = 1'b0;
    w_clear_cnt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sw.start_stop) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (sw.start_stop) begin
          w_state_nxt = ST_PAUSED;
        end else if (sw.lap) begin
          w_state_nxt = ST_LAP;
          w_load_snap = 1'b1;
        end
      end
      ST_LAP: begin
        if (sw.start_stop) begin
          w_state_nxt = ST_PAUSED;
        end else if (sw.lap) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_PAUSED: begin
        if (sw.clear) begin
          w_state_nxt = ST_IDLE;
          w_clear_cnt = 1'b1;
        end else if (sw.start_stop) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sync     <= '0;
      r_hist     <= 1'b0;
      r_overflow <= 1'b0;
      r_cnt      <= '0;
      r_snap     <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], sw.tick_in};
      r_hist  <= r_sync[SYNC_STAGES-1];
      r_state <= w_state_nxt;
      if (w_clear_cnt) begin
        r_cnt      <= '0;
        r_overflow <= 1'b0;
      end else if (w_cnt_en) begin
        r_cnt <= w_cnt_inc;
        if (w_wrap) r_overflow <= 1'b1;
      end
      // snapshot takes the pre-increment count even when a tick lands on the lap edge
      if (w_load_snap) r_snap <= r_cnt;
    end
  end

  assign w_disp        = (r_state == ST_LAP) ? r_snap : r_cnt;
  assign sw.cs_ones    = w_disp[0];
  assign sw.cs_tens    = w_disp[1];
  assign sw.sec_ones   = w_disp[2];
  assign sw.sec_tens   = w_disp[3];
  assign sw.min_ones   = w_disp[4];
  assign sw.min_tens   = w_disp[5];
  assign sw.running    = (r_state == ST_RUN) | (r_state == ST_LAP);
  assign sw.lap_active = (r_state == ST_LAP);
  assign sw.overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// tb/tb_stopwatch_bcd_counter.sv - directed self-checking bench for stopwatch_bcd_counter
module tb_stopwatch_bcd_counter;

  // one-minute ceiling keeps the wrap scenario within a short run
  localparam int MAX_MIN = 1;

  logic clkin = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clkin = ~clkin;

  stopwatch_bcd_counter_if sw ();

  stopwatch_bcd_counter #(
    .SYNC_STAGES(2),
    .MAX_MINUTES(MAX_MIN)
  ) u_dut (
    .clkin(clkin),
    .rst  (rst),
    .sw   (sw)
  );

  function automatic logic [23:0] disp();
    return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones, sw.cs_tens, sw.cs_ones};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic pulse(input logic ss, input logic cl, input logic lp);
    sw.start_stop = ss;
    sw.clear      = cl;
    sw.lap        = lp;
    step();
    sw.start_stop = 1'b0;
    sw.clear      = 1'b0;
    sw.lap        = 1'b0;
  endtask

  task automatic send_tick(input int hi, input int lo);
    sw.tick_in = 1'b1;
    step(hi);
    sw.tick_in = 1'b0;
    step(lo);
  endtask

  task automatic fast_ticks(input int n);
    repeat (n) send_tick(1, 1);
    step(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sw.tick_in = 1'b0;
    sw.start_stop = 1'b0;
    sw.clear = 1'b0;
    sw.lap = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_digits", 32'(disp()), 32'h000000);
    check("rst_running", 32'(sw.running), 32'd0);
    check("rst_lap", 32'(sw.lap_active), 32'd0);
    check("rst_ovf", 32'(sw.overflow), 32'd0);

    // 150 ticks, first one with explicit 3-edge latency check
    pulse(1'b1, 1'b0, 1'b0);
    check("start_running", 32'(sw.running), 32'd1);
    sw.tick_in = 1'b1;
    step(2);
    check("lat_before", 32'(disp()), 32'h000000);
    step();
    check("lat_after", 32'(disp()), 32'h000001);
    step(4);
    sw.tick_in = 1'b0;
    step(5);
    repeat (99) send_tick(7, 5);
    check("t1_100", 32'(disp()), 32'h000100);
    repeat (50) send_tick(7, 5);
    check("t1_150", 32'(disp()), 32'h000150);
    check("t1_running", 32'(sw.running), 32'd1);
    check("t1_ovf", 32'(sw.overflow), 32'd0);

    // long high level yields a single increment
    send_tick(40, 5);
    check("long_high", 32'(disp()), 32'h000151);

    // lap freeze at 00:00.42
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    fast_ticks(42);
    check("pre_lap", 32'(disp()), 32'h000042);
    pulse(1'b0, 1'b0, 1'b1);
    check("lap_on", 32'(sw.lap_active), 32'd1);
    check("lap_running", 32'(sw.running), 32'd1);
    repeat (10) send_tick(3, 3);
    check("lap_frozen", 32'(disp()), 32'h000042);
    pulse(1'b0, 1'b0, 1'b1);
    check("lap_release", 32'(disp()), 32'h000052);
    check("lap_off", 32'(sw.lap_active), 32'd0);

    // start_stop coincident with tick at 00:09.99
    fast_ticks(947);
    check("at_999", 32'(disp()), 32'h000999);
    sw.tick_in = 1'b1;
    step(2);
    pulse(1'b1, 1'b0, 1'b0);
    sw.tick_in = 1'b0;
    step(3);
    check("ss_tick_count", 32'(disp()), 32'h001000);
    check("ss_paused", 32'(sw.running), 32'd0);
    repeat (3) send_tick(3, 3);
    check("paused_hold", 32'(disp()), 32'h001000);
    pulse(1'b0, 1'b1, 1'b0);
    check("clear_digits", 32'(disp()), 32'h000000);
    check("clear_idle", 32'(sw.running), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    check("idle_lap_ign", 32'(sw.lap_active), 32'd0);

    // wrap past MAX_MIN:59.99
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    fast_ticks(11998);
    check("pre_wrap", 32'(disp()), 32'h015998);
    send_tick(3, 3);
    check("max_value", 32'(disp()), 32'h015999);
    check("max_no_ovf", 32'(sw.overflow), 32'd0);
    send_tick(3, 3);
    check("wrap_digits", 32'(disp()), 32'h000000);
    check("wrap_ovf", 32'(sw.overflow), 32'd1);
    check("wrap_running", 32'(sw.running), 32'd1);
    send_tick(3, 3);
    check("post_wrap", 32'(disp()), 32'h000001);
    pulse(1'b0, 1'b1, 1'b0);
    check("run_clear_ign", 32'(sw.overflow), 32'd1);
    check("run_clear_dig", 32'(disp()), 32'h000001);
    pulse(1'b1, 1'b0, 1'b0);
    check("wrap_paused", 32'(sw.running), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    check("ovf_cleared", 32'(sw.overflow), 32'd0);

    // reset while in LAP, with tick_in high
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    fast_ticks(5);
    pulse(1'b0, 1'b0, 1'b1);
    fast_ticks(3);
    check("lap_snap5", 32'(disp()), 32'h000005);
    sw.tick_in = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_dig", 32'(disp()), 32'h000000);
    check("mid_rst_run", 32'(sw.running), 32'd0);
    check("mid_rst_lap", 32'(sw.lap_active), 32'd0);
    step(4);
    check("rst_pulse_ign", 32'(disp()), 32'h000000);
    sw.tick_in = 1'b0;
    step(3);
    pulse(1'b1, 1'b0, 1'b0);
    send_tick(3, 3);
    check("resume", 32'(disp()), 32'h000001);
    check("resume_run", 32'(sw.running), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
